// File: rtl/adc_scan_scheduler_if.sv
// Signal bundle between the ADC scan scheduler, the sensor requesters and the ADC pins.
interface adc_scan_scheduler_if;
  logic [7:0]  req;
  logic [7:0]  pending;
  logic        busy;
  logic        data_valid;
  logic [2:0]  data_ch;
  logic [11:0] data_out;
  logic        adc_cs_n;
  logic        adc_sck;
  logic        adc_din;
  logic        adc_dout;

  modport master (
    input  req, adc_dout,
    output pending, busy, data_valid, data_ch, data_out, adc_cs_n, adc_sck, adc_din
  );

  modport slave (
    output req, adc_dout,
    input  pending, busy, data_valid, data_ch, data_out, adc_cs_n, adc_sck, adc_din
  );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Round-robin scheduler sharing one 8-channel serial ADC (16-SCLK frames) between 8 requesters.
// state | meaning: IDLE wait/arbitrate, SETUP cs low sck high, SHIFT 16 sck periods, HOLD sck high tail, GAP cs high + publish
module adc_scan_scheduler #(
  parameter int unsigned SCK_HALF = 8,
  parameter int unsigned CS_GAP   = 8
) (
  input  logic clk_50M,
  input  logic reset,
  adc_scan_scheduler_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int unsigned CNT_MAX = (SCK_HALF > CS_GAP) ? SCK_HALF : CS_GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LD = CW'(SCK_HALF - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(CS_GAP - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [4:0]    bit_idx, bit_idx_d;
  logic [2:0]    cur_addr, cur_addr_d;
  logic [2:0]    prev_addr, prev_addr_d;
  logic [2:0]    rr_ptr, rr_ptr_d;
  logic [11:0]   shreg, shreg_d;
  logic [7:0]    pending, pending_d;
  logic          busy, busy_d;
  logic          data_valid, data_valid_d;
  logic [2:0]    data_ch, data_ch_d;
  logic [11:0]   data_out, data_out_d;
  logic          cs_n, cs_n_d;
  logic          sck, sck_d;
  logic          din, din_d;

  logic [7:0]    clr;
  logic [2:0]    cand;
  logic [2:0]    win;
  logic          win_found;
  logic [4:0]    nb;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    bit_idx_d    = bit_idx;
    cur_addr_d   = cur_addr;
    prev_addr_d  = prev_addr;
    rr_ptr_d     = rr_ptr;
    shreg_d      = shreg;
    busy_d       = busy;
    data_valid_d = 1'b0;
    data_ch_d    = data_ch;
    data_out_d   = data_out;
    cs_n_d       = cs_n;
    sck_d        = sck;
    din_d        = din;
    clr          = '0;
    cand         = '0;
    win          = '0;
    win_found    = 1'b0;
    nb           = bit_idx + 5'd1;

    // Search starts one past the last winner; i == 8 wraps back onto rr_ptr itself.
    for (int i = 1; i <= 8; i++) begin
      cand = rr_ptr + 3'(i);
      if (!win_found && pending[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end

    case (state)
      IDLE: begin
        if (win_found) begin
          cur_addr_d = win;
          rr_ptr_d   = win;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          bit_idx_d  = '0;
          cnt_d      = HALF_LD;
          state_d    = SETUP;
        end
      end
      SETUP, SHIFT: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          cnt_d = HALF_LD;
          if (state == SHIFT && !sck) begin
            sck_d = 1'b1;
            if (bit_idx >= 5'd5) shreg_d = {shreg[10:0], bus.adc_dout};
          end else if (bit_idx == 5'd16) begin
            state_d = HOLD;
          end else begin
            sck_d     = 1'b0;
            bit_idx_d = nb;
            state_d   = SHIFT;
            din_d     = (nb == 5'd3) ? cur_addr[2] :
                        (nb == 5'd4) ? cur_addr[1] :
                        (nb == 5'd5) ? cur_addr[0] : 1'b0;
          end
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          cs_n_d  = 1'b1;
          cnt_d   = GAP_LD;
          state_d = GAP;
          // The shifted result is the conversion requested by the previous frame.
          if (pending[prev_addr]) begin
            data_valid_d   = 1'b1;
            data_ch_d      = prev_addr;
            data_out_d     = shreg;
            clr[prev_addr] = 1'b1;
          end
          prev_addr_d = cur_addr;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d = (pending & ~clr) | bus.req;
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      cur_addr   <= '0;
      prev_addr  <= '0;
      rr_ptr     <= 3'd7;
      shreg      <= '0;
      pending    <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_ch    <= '0;
      data_out   <= '0;
      cs_n       <= 1'b1;
      sck        <= 1'b1;
      din        <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      cur_addr   <= cur_addr_d;
      prev_addr  <= prev_addr_d;
      rr_ptr     <= rr_ptr_d;
      shreg      <= shreg_d;
      pending    <= pending_d;
      busy       <= busy_d;
      data_valid <= data_valid_d;
      data_ch    <= data_ch_d;
      data_out   <= data_out_d;
      cs_n       <= cs_n_d;
      sck        <= sck_d;
      din        <= din_d;
    end
  end

  assign bus.pending    = pending;
  assign bus.busy       = busy;
  assign bus.data_valid = data_valid;
  assign bus.data_ch    = data_ch;
  assign bus.data_out   = data_out;
  assign bus.adc_cs_n   = cs_n;
  assign bus.adc_sck    = sck;
  assign bus.adc_din    = din;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: ADC pin model plus a frame-level request/publish reference model.
module tb_adc_scan_scheduler;
  localparam int H = 8;
  localparam int G = 8;

  logic clk_50M = 1'b0;
  logic reset   = 1'b1;

  adc_scan_scheduler_if bus ();

  adc_scan_scheduler #(.SCK_HALF(H), .CS_GAP(G)) dut (
    .clk_50M(clk_50M),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_50M = ~clk_50M;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] conv [8];
  logic [7:0]  m_pending = '0;
  logic [2:0]  m_prev    = '0;
  logic [2:0]  m_rr      = 3'd7;
  int          frames    = 0;
  int          stray     = 0;
  logic [2:0]  strobe_log [$];
  logic [2:0]  addr_log   [$];

  // monitor-private state
  logic        cs_prev = 1'b1, sck_prev = 1'b1, busy_prev = 1'b0, rst_prev = 1'b0;
  logic [7:0]  req_prev = '0;
  logic        in_frame = 1'b0, have_gap = 1'b0, event_seen, exp_strobe;
  logic [2:0]  fr_addr = '0, rx_addr = '0, adc_ch = '0;
  logic [11:0] w;
  int          cyc = 0, low_len = 0, fall_cnt = 0, rise_cnt = 0, last_fall = 0;
  int          min_sp = 0, max_sp = 0, gap_cnt = 0, busy_len = 0, sp;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rr_pick(input logic [7:0] p, input logic [2:0] ptr);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (int'(ptr) + k) % 8;
      if (p[c]) return 3'(c);
    end
    return ptr;
  endfunction

  // ADC pins + reference model, evaluated once per cycle on the falling clock edge.
  initial begin
    bus.adc_dout = 1'b0;
    forever begin
      @(negedge clk_50M);
      event_seen = 1'b0;
      if (rst_prev) begin
        check_val("rst_cs_n", bus.adc_cs_n, 1);
        check_val("rst_sck", bus.adc_sck, 1);
        check_val("rst_din", bus.adc_din, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_valid", bus.data_valid, 0);
        check_val("rst_ch", bus.data_ch, 0);
        check_val("rst_data", bus.data_out, 0);
        check_val("rst_pending", bus.pending, 0);
        m_pending = '0; m_prev = '0; m_rr = 3'd7; adc_ch = '0;
        bus.adc_dout = 1'b0;
        in_frame = 1'b0; have_gap = 1'b0; busy_len = 0; gap_cnt = 0;
      end else begin
        if (cs_prev && !bus.adc_cs_n) begin
          event_seen = 1'b1;
          check_val("start_pend", m_pending != 0, 1);
          if (have_gap) check_val("cs_gap", gap_cnt >= G, 1);
          fr_addr = rr_pick(m_pending, m_rr);
          m_rr = fr_addr;
          in_frame = 1'b1; low_len = 0; fall_cnt = 0; rise_cnt = 0; rx_addr = '0;
          last_fall = 0; min_sp = 1000000; max_sp = 0;
        end
        if (in_frame && !bus.adc_cs_n) begin
          low_len++;
          if (sck_prev && !bus.adc_sck) begin
            fall_cnt++;
            if (fall_cnt > 1) begin
              sp = cyc - last_fall;
              if (sp < min_sp) min_sp = sp;
              if (sp > max_sp) max_sp = sp;
            end
            last_fall = cyc;
            if (fall_cnt >= 5 && fall_cnt <= 16) begin
              w = conv[adc_ch];
              bus.adc_dout = w[16-fall_cnt];
            end else begin
              bus.adc_dout = 1'b0;
            end
          end
          if (!sck_prev && bus.adc_sck) begin
            rise_cnt++;
            if (rise_cnt >= 3 && rise_cnt <= 5) rx_addr = {rx_addr[1:0], bus.adc_din};
          end
        end
        if (in_frame && !cs_prev && bus.adc_cs_n) begin
          event_seen = 1'b1;
          check_val("cs_low_len", low_len, 34*H);
          check_val("sck_falls", fall_cnt, 16);
          check_val("sck_min_sp", min_sp, 2*H);
          check_val("sck_max_sp", max_sp, 2*H);
          check_val("din_addr", rx_addr, fr_addr);
          exp_strobe = m_pending[m_prev];
          check_val("strobe", bus.data_valid, exp_strobe);
          if (exp_strobe) begin
            check_val("strobe_ch", bus.data_ch, m_prev);
            check_val("strobe_data", bus.data_out, conv[m_prev]);
            strobe_log.push_back(m_prev);
            m_pending[m_prev] = 1'b0;
          end
          addr_log.push_back(fr_addr);
          m_prev = fr_addr;
          adc_ch = rx_addr;
          in_frame = 1'b0; have_gap = 1'b1; gap_cnt = 0;
          frames++;
        end else if (bus.data_valid) begin
          stray++;
        end
        if (bus.adc_cs_n) gap_cnt++;
        if (bus.adc_cs_n && !bus.adc_sck) stray++;
        if (!bus.adc_cs_n && !bus.busy) stray++;
        if (bus.busy) busy_len++;
        else if (busy_prev) begin
          check_val("busy_len", busy_len, 34*H + G);
          busy_len = 0;
        end
        m_pending = m_pending | req_prev;
        if (event_seen) check_val("pending", bus.pending, m_pending);
      end
      cyc++;
      cs_prev = bus.adc_cs_n; sck_prev = bus.adc_sck; busy_prev = bus.busy;
      rst_prev = reset; req_prev = bus.req;
    end
  end

  task automatic pulse_req(input logic [7:0] v);
    @(posedge clk_50M); #1 bus.req = v;
    @(posedge clk_50M); #1 bus.req = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_50M); #1 reset = 1'b1;
    repeat (2) @(posedge clk_50M);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    repeat (2) @(negedge clk_50M);
    while (!(bus.pending == 0 && !bus.busy) && n < limit) begin
      @(negedge clk_50M);
      n++;
    end
    if (n >= limit) check_val("idle_timeout", {bus.pending, bus.busy}, 0);
  endtask

  task automatic wait_cs(input logic v, input int limit);
    int n;
    n = 0;
    while (bus.adc_cs_n !== v && n < limit) begin
      @(negedge clk_50M);
      n++;
    end
    if (n >= limit) check_val("cs_timeout", bus.adc_cs_n, v);
  endtask

  task automatic randomize_conv();
    for (int k = 0; k < 8; k++) conv[k] = 12'($urandom);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, s0, a0, n3;
    bus.req = '0;
    randomize_conv();
    conv[0] = 12'hA5C;
    repeat (3) @(posedge clk_50M);
    #1 reset = 1'b0;

    // single channel 0 from reset
    f0 = frames; s0 = strobe_log.size();
    pulse_req(8'h01);
    wait_idle(2000);
    check_val("s1_frames", frames - f0, 1);
    check_val("s1_strobes", strobe_log.size() - s0, 1);
    check_val("s1_addr", addr_log[addr_log.size()-1], 0);
    check_val("s1_ch", bus.data_ch, 0);
    check_val("s1_data", bus.data_out, 12'hA5C);
    check_val("s1_pending", bus.pending, 0);

    // channel 5 alone needs two frames
    f0 = frames; s0 = strobe_log.size();
    pulse_req(8'h20);
    wait_idle(2000);
    check_val("s2_frames", frames - f0, 2);
    check_val("s2_strobes", strobe_log.size() - s0, 1);
    check_val("s2_ch", bus.data_ch, 5);
    check_val("s2_data", bus.data_out, conv[5]);

    // all channels at once
    randomize_conv();
    do_reset();
    f0 = frames; s0 = strobe_log.size(); a0 = addr_log.size();
    pulse_req(8'hFF);
    wait_idle(5000);
    check_val("s3_frames", frames - f0, 9);
    check_val("s3_strobes", strobe_log.size() - s0, 8);
    for (int k = 0; k < 8; k++) begin
      if (s0 + k < strobe_log.size()) check_val("s3_strobe_order", strobe_log[s0+k], k);
      if (a0 + k < addr_log.size())   check_val("s3_addr_order", addr_log[a0+k], k);
    end
    check_val("s3_pending", bus.pending, 0);

    // reset 100 cycles into a frame
    pulse_req(8'h46);
    wait_cs(1'b0, 100);
    repeat (100) @(posedge clk_50M);
    #1 reset = 1'b1;
    @(posedge clk_50M); #1 reset = 1'b0;
    @(negedge clk_50M);
    check_val("s5_cs_n", bus.adc_cs_n, 1);
    check_val("s5_sck", bus.adc_sck, 1);
    check_val("s5_pending", bus.pending, 0);
    check_val("s5_valid", bus.data_valid, 0);
    f0 = frames; s0 = strobe_log.size();
    pulse_req(8'h01);
    wait_idle(2000);
    check_val("s5_frames", frames - f0, 1);
    check_val("s5_strobes", strobe_log.size() - s0, 1);

    // re-request ch3 on the exact cycle its pending bit clears
    do_reset();
    f0 = frames; s0 = strobe_log.size();
    pulse_req(8'h08);
    wait_cs(1'b0, 100);
    wait_cs(1'b1, 400);
    wait_cs(1'b0, 100);
    repeat (34*H - 1) @(posedge clk_50M);
    #1 bus.req = 8'h08;
    @(posedge clk_50M); #1 bus.req = '0;
    @(negedge clk_50M);
    check_val("s6_valid", bus.data_valid, 1);
    check_val("s6_ch", bus.data_ch, 3);
    check_val("s6_pend3", bus.pending[3], 1);
    wait_idle(3000);
    n3 = 0;
    for (int k = s0; k < strobe_log.size(); k++) if (strobe_log[k] == 3'd3) n3++;
    check_val("s6_ch3_count", n3, 2);
    check_val("s6_frames", frames - f0, 3);

    // random request bursts against the reference model
    randomize_conv();
    repeat (30) begin
      repeat ($urandom_range(0, 350)) @(posedge clk_50M);
      pulse_req(8'($urandom));
    end
    wait_idle(30000);
    check_val("rnd_pending", bus.pending, 0);
    repeat (4) @(negedge clk_50M);
    check_val("stray_events", stray, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
